tl_rx_cpl_write_handler: RTL
============================

# tl_rx_cpl_write_handler

Writer side of the RX completion virtual-channel buffers. It accepts completion TLPs from the data-link layer as a beat stream and writes each header into the completion header buffer and its payload into the completion data buffer. It commits or rolls back each TLP and reports the flow-control credits consumed. The completion read handler drains these same buffers toward the AXI slave.

## Interface

Parameters:

- `PAYLOAD_LENGTH`, default 10: width of the TLP length field in DW.
- `DATA_BEAT_DW`, default 8: number of DW per beat; the beat is 256 bits.
- `HDR_WIDTH`, default 128: header width in bits, 3DW or 4DW, left-aligned.
- `VALID_DATA_WIDTH`, default 5: width of the valid-DW count on a data write.
- `CPLD_CREDIT_WIDTH`, default 9: width of the data-credit count; must hold 256.

Ports:

- `i_clk` in 1: the single clock.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_tlp_valid` in 1: a beat is presented.
- `i_tlp_sop` in 1: first beat; its bits [HDR_WIDTH-1:0] carry the header.
- `i_tlp_eop` in 1: last beat.
- `i_tlp_data` in 32*DATA_BEAT_DW: beat payload.
- `i_tlp_drop` in 1: qualified with eop; requests discard of the TLP (ECRC or poison).
- `o_tlp_ready` out 1: the beat is accepted when valid and ready are both high.
- `i_hdr_full` in 1: completion header buffer is full.
- `o_hdr_wr_en` out 1: header write strobe.
- `o_hdr_wr_data` out HDR_WIDTH: header written to the buffer.
- `i_data_full` in 1: completion data buffer is full.
- `o_data_wr_en` out 1: data write strobe.
- `o_data_wr_data` out 32*DATA_BEAT_DW: data written to the buffer.
- `o_data_valid_dw` out VALID_DATA_WIDTH: number of valid DW in this write (1..8).
- `o_commit` out 1: pulse; publishes the writes of the current TLP.
- `o_rollback` out 1: pulse; discards the writes of the current TLP.
- `o_cpl_credit_vld` out 1: pulse; the credit counts below are valid.
- `o_cplh_credits` out 1: header credit consumed.
- `o_cpld_credits` out CPLD_CREDIT_WIDTH: data credits consumed.
- `o_malformed` out 1: pulse; the TLP was malformed.

## Operation

- The FSM has three states: IDLE, DATA and DISCARD.
- **IDLE**
  - `o_tlp_ready` = ~`i_hdr_full`.
  - An accepted sop beat asserts `o_hdr_wr_en` in the same cycle, with the header taken from the beat.
  - Header fields: fmt-data bit = hdr[30]; length = hdr[9:0]. A length of 0 means 1024 DW.
  - If the data bit is 0 and eop is high, the TLP is complete: stay in IDLE and commit.
  - If the data bit is 1, load the remaining-DW counter with the length (1024 when length is 0) and go to DATA.
  - If the data bit is 0 and eop is low, the TLP is malformed: go to DISCARD.
  - A non-sop beat in IDLE is accepted and dropped, and `o_malformed` pulses.
- **DATA**
  - `o_tlp_ready` = ~`i_data_full`.
  - Each accepted beat asserts `o_data_wr_en` with `o_data_valid_dw` = min(remaining, 8), then decrements remaining by 8.
  - Last expected beat (remaining ≤ 8) with eop: finish, go to IDLE.
  - Last expected beat without eop: malformed, go to DISCARD.
  - eop before the last expected beat: malformed, roll back, go to IDLE.
  - sop seen in DATA: the beat is not written, malformed, go to DISCARD; if that beat also carries eop, roll back and go to IDLE.
- **DISCARD**
  - `o_tlp_ready` = 1 and no writes are issued.
  - On eop: go to IDLE and roll back.
- **Finish:** commit, unless a drop is requested (see Configuration).
- **Credits:** on commit only, `o_cplh_credits` = 1 and `o_cpld_credits` = ceil(length_DW/4). A length of 0 gives 256 credits; a no-data completion gives 0. No credits are reported on rollback.
- **Arithmetic:** the remaining counter is PAYLOAD_LENGTH+1 bits wide and never underflows (it saturates at 0).

## Timing

- Write strobes and write data are combinational from the accepted beat, giving zero latency. `o_tlp_ready` is combinational from the state and the full flags.
- `o_commit`/`o_rollback`, `o_cpl_credit_vld` with the credit counts, and `o_malformed` are registered. They pulse for exactly one cycle, in the cycle after the eop (or offending) beat is accepted.
- Commit and rollback are mutually exclusive.
- Back-to-back TLPs are supported: a sop may be accepted in the cycle after an eop. The pulse for the previous TLP overlaps the new header write.
- A full flag asserting mid-TLP stalls the stream and does not abort it. A stall on the eop beat delays the commit.
- Reset values: state IDLE; remaining counter 0; every pulse output and strobe is 0; `o_tlp_ready` resolves from IDLE.
- Reset mid-TLP: return to IDLE and emit no commit or rollback. The buffers are reset by the same `i_rst`.

## Configuration

- `TL_RX_CPL_ECRC_DROP_EN` defined: `i_tlp_drop` sampled on the accepted eop beat turns the commit into a rollback, with no credits reported and `o_malformed` low.
- Not defined: `i_tlp_drop` is ignored and well-formed TLPs always commit. `o_rollback` is driven only by malformed cases.

## Structure

- Package `tl_rx_cpl_pkg` holds:
  - the state enum;
  - the header field offsets (FMT_DATA_BIT = 30, LENGTH_LSB/MSB);
  - DATA_BEAT_DW;
  - the 1024-DW zero-length constant.
- Sub-module `tl_rx_cpl_credit_calc` is registered. It latches the length at sop and presents the credit counts at commit.

## Test plan

- 3DW completion without data (sop = eop): one header write, then the next cycle commit with cplh = 1 and cpld = 0.
- CplD with length 20: header write and three data writes with valid_dw 8, 8, 4; then commit with cpld = 5.
- CplD with length 0: 128 data writes, each with valid_dw 8; commit with cpld = 256; the counter does not wrap.
- CplD with length 20 and eop on the 2nd data beat: the next cycle brings malformed and rollback, with no credit pulse.
- `i_data_full` held for 5 cycles mid-TLP: ready stays low and there are no writes; the stream resumes and the write sequence is unchanged.
- With `TL_RX_CPL_ECRC_DROP_EN` defined, a length-8 CplD with drop on eop: rollback, no credits, `o_malformed` = 0. Without the macro, the same stimulus commits with cpld = 2.

Source files
------------

// File: rtl/tl_rx_cpl_pkg.sv
// Shared definitions for the RX completion buffer write path: FSM states,
// completion header field positions and beat geometry.
package tl_rx_cpl_pkg;

    // Writer FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Completion header field positions (header left-aligned in the beat)
    localparam int FMT_DATA_BIT = 30;
    localparam int LENGTH_LSB   = 0;
    localparam int LENGTH_MSB   = 9;

    // DW carried by one data beat
    localparam int DATA_BEAT_DW = 8;

    // A length field of zero encodes the maximum payload
    localparam int ZERO_LEN_DW  = 1024;

endpackage

// File: rtl/tl_rx_cpl_credit_calc.sv
// Completion credit calculator. Latches the data-credit cost of a TLP when
// its header is accepted and presents the header/data credits for one cycle
// after the TLP commits. A header-only completion (sop = eop) commits in the
// same cycle its header arrives, so the fresh value bypasses the latch.
module tl_rx_cpl_credit_calc #(
    parameter int PAYLOAD_LENGTH    = 10,
    parameter int CPLD_CREDIT_WIDTH = 9
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_hdr_accept,
    input  logic                         i_has_data,
    input  logic [PAYLOAD_LENGTH-1:0]    i_length,
    input  logic                         i_commit,
    output logic                         o_credit_vld,
    output logic                         o_cplh_credits,
    output logic [CPLD_CREDIT_WIDTH-1:0] o_cpld_credits
);
    import tl_rx_cpl_pkg::*;

    localparam int LW = PAYLOAD_LENGTH + 1;

    logic [LW-1:0]                w_len_dw;
    logic [CPLD_CREDIT_WIDTH-1:0] w_hdr_credits;
    logic [CPLD_CREDIT_WIDTH-1:0] w_credits_now;
    logic [CPLD_CREDIT_WIDTH-1:0] r_cpld_latched;
    logic                         r_credit_vld;
    logic                         r_cplh;
    logic [CPLD_CREDIT_WIDTH-1:0] r_cpld;

    // Data credits are 4 DW each, rounded up; no-data completions cost none
    always_comb begin
        w_len_dw      = (i_length == '0) ? LW'(ZERO_LEN_DW) : {1'b0, i_length};
        w_hdr_credits = i_has_data ? CPLD_CREDIT_WIDTH'((w_len_dw + LW'(3)) >> 2) : '0;
        w_credits_now = i_hdr_accept ? w_hdr_credits : r_cpld_latched;
    end

    // Latch the cost at header time, publish it the cycle after commit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cpld_latched <= '0;
            r_credit_vld   <= 1'b0;
            r_cplh         <= 1'b0;
            r_cpld         <= '0;
        end else begin
            if (i_hdr_accept) begin
                r_cpld_latched <= w_hdr_credits;
            end
            r_credit_vld <= i_commit;
            r_cplh       <= i_commit;
            r_cpld       <= i_commit ? w_credits_now : '0;
        end
    end

    assign o_credit_vld   = r_credit_vld;
    assign o_cplh_credits = r_cplh;
    assign o_cpld_credits = r_cpld;

endmodule

// File: rtl/tl_rx_cpl_write_handler.sv
// Writer side of the RX completion buffers. Header goes to the header buffer
// on the sop beat, payload beats go to the data buffer, and each TLP is
// committed or rolled back one cycle after its last beat.
// Handshake: a beat transfers on a cycle where i_tlp_valid and o_tlp_ready
// are both high; ready never depends on valid.
// Optional feature macro: TL_RX_CPL_ECRC_DROP_EN (i_tlp_drop on the eop beat
// turns a commit into a rollback).
module tl_rx_cpl_write_handler #(
    parameter int PAYLOAD_LENGTH    = 10,
    parameter int DATA_BEAT_DW      = 8,
    parameter int HDR_WIDTH         = 128,
    parameter int VALID_DATA_WIDTH  = 5,
    parameter int CPLD_CREDIT_WIDTH = 9
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_tlp_valid,
    input  logic                         i_tlp_sop,
    input  logic                         i_tlp_eop,
    input  logic [32*DATA_BEAT_DW-1:0]   i_tlp_data,
    input  logic                         i_tlp_drop,
    output logic                         o_tlp_ready,
    input  logic                         i_hdr_full,
    output logic                         o_hdr_wr_en,
    output logic [HDR_WIDTH-1:0]         o_hdr_wr_data,
    input  logic                         i_data_full,
    output logic                         o_data_wr_en,
    output logic [32*DATA_BEAT_DW-1:0]   o_data_wr_data,
    output logic [VALID_DATA_WIDTH-1:0]  o_data_valid_dw,
    output logic                         o_commit,
    output logic                         o_rollback,
    output logic                         o_cpl_credit_vld,
    output logic                         o_cplh_credits,
    output logic [CPLD_CREDIT_WIDTH-1:0] o_cpld_credits,
    output logic                         o_malformed,
    output logic [1:0]                   o_dbg_state
);
    import tl_rx_cpl_pkg::*;

    localparam int RW = PAYLOAD_LENGTH + 1;

    state_t                    r_state, w_state_nxt;
    logic [RW-1:0]             r_rem, w_rem_nxt;
    logic                      r_commit, r_rollback, r_malformed;
    logic                      w_ready, w_accept, w_drop;
    logic                      w_hdr_wr_en, w_data_wr_en;
    logic                      w_finish, w_abort, w_malformed;
    logic                      w_commit_req, w_rollback_req;
    logic                      w_hdr_has_data;
    logic [PAYLOAD_LENGTH-1:0] w_hdr_len;
    logic [RW-1:0]             w_load_len;

`ifdef TL_RX_CPL_ECRC_DROP_EN
    assign w_drop = i_tlp_drop;
`else
    assign w_drop = 1'b0 & i_tlp_drop;
`endif

    assign w_hdr_has_data = i_tlp_data[FMT_DATA_BIT];
    assign w_hdr_len      = i_tlp_data[LENGTH_MSB:LENGTH_LSB];
    assign w_load_len     = (w_hdr_len == '0) ? RW'(ZERO_LEN_DW) : RW'(w_hdr_len);

    // Ready comes only from state and the buffer full flags
    always_comb begin
        case (r_state)
            ST_IDLE: w_ready = ~i_hdr_full;
            ST_DATA: w_ready = ~i_data_full;
            default: w_ready = 1'b1;
        endcase
    end
    assign w_accept = i_tlp_valid & w_ready;

    // Next state, remaining-DW count, write strobes and end-of-TLP outcome
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_hdr_wr_en  = 1'b0;
        w_data_wr_en = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        w_malformed  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (i_tlp_sop) begin
                        w_hdr_wr_en = 1'b1;
                        if (!w_hdr_has_data) begin
                            if (i_tlp_eop) begin
                                w_finish = 1'b1;
                            end else begin
                                w_malformed = 1'b1;
                                w_state_nxt = ST_DISCARD;
                            end
                        end else if (i_tlp_eop) begin
                            // Data promised but the TLP ended on its header
                            w_malformed = 1'b1;
                            w_abort     = 1'b1;
                        end else begin
                            w_rem_nxt   = w_load_len;
                            w_state_nxt = ST_DATA;
                        end
                    end else begin
                        w_malformed = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    if (i_tlp_sop) begin
                        w_malformed = 1'b1;
                        if (i_tlp_eop) begin
                            w_abort     = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DISCARD;
                        end
                    end else begin
                        w_data_wr_en = 1'b1;
                        if (r_rem <= RW'(DATA_BEAT_DW)) begin
                            w_rem_nxt = '0;
                            if (i_tlp_eop) begin
                                w_finish    = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_malformed = 1'b1;
                                w_state_nxt = ST_DISCARD;
                            end
                        end else begin
                            w_rem_nxt = r_rem - RW'(DATA_BEAT_DW);
                            if (i_tlp_eop) begin
                                w_malformed = 1'b1;
                                w_abort     = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (w_accept && i_tlp_eop) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_commit_req   = w_finish & ~w_drop;
    assign w_rollback_req = w_abort | (w_finish & w_drop);

    // State, counter and the one-cycle outcome pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_commit    <= 1'b0;
            r_rollback  <= 1'b0;
            r_malformed <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_commit    <= w_commit_req;
            r_rollback  <= w_rollback_req;
            r_malformed <= w_malformed;
        end
    end

    tl_rx_cpl_credit_calc #(
        .PAYLOAD_LENGTH    (PAYLOAD_LENGTH),
        .CPLD_CREDIT_WIDTH (CPLD_CREDIT_WIDTH)
    ) u_credit_calc (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_hdr_accept   (w_hdr_wr_en),
        .i_has_data     (w_hdr_has_data),
        .i_length       (w_hdr_len),
        .i_commit       (w_commit_req),
        .o_credit_vld   (o_cpl_credit_vld),
        .o_cplh_credits (o_cplh_credits),
        .o_cpld_credits (o_cpld_credits)
    );

    assign o_tlp_ready     = w_ready;
    assign o_hdr_wr_en     = w_hdr_wr_en;
    assign o_hdr_wr_data   = i_tlp_data[HDR_WIDTH-1:0];
    assign o_data_wr_en    = w_data_wr_en;
    assign o_data_wr_data  = i_tlp_data;
    assign o_data_valid_dw = (r_rem >= RW'(DATA_BEAT_DW)) ? VALID_DATA_WIDTH'(DATA_BEAT_DW)
                                                          : VALID_DATA_WIDTH'(r_rem);
    assign o_commit        = r_commit;
    assign o_rollback      = r_rollback;
    assign o_malformed     = r_malformed;
    assign o_dbg_state     = r_state;

endmodule
